// File: rtl/sys_bus_arbiter_if.sv
// rtl/sys_bus_arbiter_if.sv - cache-side and memory-side bus bundle for sys_bus_arbiter
interface sys_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_strobe;
  logic                  i_rw;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_done;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_strobe;
  logic                  d_rw;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_done;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_strobe;
  logic                  mem_rw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;
  logic                  grant_d;

  // arbiter side
  modport slave (
    input  i_strobe, i_rw, i_addr, i_wdata,
    input  d_strobe, d_rw, d_addr, d_wdata,
    input  mem_rdata,
    output i_done, i_rdata, d_done, d_rdata,
    output mem_strobe, mem_rw, mem_addr, mem_wdata,
    output busy, grant_d
  );

  // cache controllers plus memory model side
  modport master (
    output i_strobe, i_rw, i_addr, i_wdata,
    output d_strobe, d_rw, d_addr, d_wdata,
    output mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata,
    input  mem_strobe, mem_rw, mem_addr, mem_wdata,
    input  busy, grant_d
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// rtl/sys_bus_arbiter.sv - round-robin I/D cache arbiter for the shared memory bus
module sys_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  sys_bus_arbiter_if.slave   bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0] wait_cnt;

  logic                  pend_i;
  logic                  i_rw_q;
  logic [ADDR_WIDTH-1:0] i_addr_q;
  logic [DATA_WIDTH-1:0] i_wdata_q;
  logic                  pend_d;
  logic                  d_rw_q;
  logic [ADDR_WIDTH-1:0] d_addr_q;
  logic [DATA_WIDTH-1:0] d_wdata_q;

  // grant_d_q doubles as last_grant: it names the most recent winner
  logic                  grant_d_q;
  logic                  mem_strobe_q;
  logic                  mem_rw_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  logic win_d;
  logic grant_fire;
  logic clear_i;
  logic clear_d;
  logic last_wait;
  logic done_i;
  logic done_d;
  logic busy_c;

  // Winner selection: a lone requester wins, a tie goes to the port that did not win last
  always_comb begin
    win_d      = pend_d && (!pend_i || !grant_d_q);
    grant_fire = (state == S_IDLE) && (pend_i || pend_d);
    clear_i    = (state == S_DONE) && !grant_d_q;
    clear_d    = (state == S_DONE) && grant_d_q;
    last_wait  = (state == S_WAIT) && (wait_cnt == 4'd1);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pend_i || pend_d) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd1) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs: done pulse to the owner only, busy outside IDLE
  always_comb begin
    done_i = (state == S_DONE) && !grant_d_q;
    done_d = (state == S_DONE) && grant_d_q;
    busy_c = (state != S_IDLE);
  end

  // Wait-state counter, loaded in ISSUE and run down through WAIT
  always_ff @(posedge clock) begin
    if (reset)                  wait_cnt <= 4'd0;
    else if (state == S_ISSUE)  wait_cnt <= WAIT_LOAD;
    else if (state == S_WAIT)   wait_cnt <= wait_cnt - 4'd1;
  end

  // I-side request latch; a strobe landing on its own DONE cycle re-arms the port
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_i    <= 1'b0;
      i_rw_q    <= 1'b0;
      i_addr_q  <= '0;
      i_wdata_q <= '0;
    end else if (bus.i_strobe && (!pend_i || clear_i)) begin
      pend_i    <= 1'b1;
      i_rw_q    <= bus.i_rw;
      i_addr_q  <= bus.i_addr;
      i_wdata_q <= bus.i_wdata;
    end else if (clear_i) begin
      pend_i    <= 1'b0;
    end
  end

  // D-side request latch, same rules as the I side
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_d    <= 1'b0;
      d_rw_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
    end else if (bus.d_strobe && (!pend_d || clear_d)) begin
      pend_d    <= 1'b1;
      d_rw_q    <= bus.d_rw;
      d_addr_q  <= bus.d_addr;
      d_wdata_q <= bus.d_wdata;
    end else if (clear_d) begin
      pend_d    <= 1'b0;
    end
  end

  // Grant and memory-side registers: loaded on the IDLE->ISSUE edge, held otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_d_q    <= 1'b0;
      mem_strobe_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else if (grant_fire) begin
      grant_d_q    <= win_d;
      mem_strobe_q <= 1'b1;
      mem_rw_q     <= win_d ? d_rw_q    : i_rw_q;
      mem_addr_q   <= win_d ? d_addr_q  : i_addr_q;
      mem_wdata_q  <= win_d ? d_wdata_q : i_wdata_q;
    end else begin
      mem_strobe_q <= 1'b0;
    end
  end

  // Read data capture on the last wait cycle; writes leave the rdata registers alone
  always_ff @(posedge clock) begin
    if (reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (last_wait && !mem_rw_q) begin
      if (grant_d_q) d_rdata_q <= bus.mem_rdata;
      else           i_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.i_done     = done_i;
  assign bus.d_done     = done_d;
  assign bus.i_rdata    = i_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.mem_strobe = mem_strobe_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_c;
  assign bus.grant_d    = grant_d_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb/tb_sys_bus_arbiter.sv - randomized and directed bench for sys_bus_arbiter
module tb_sys_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sys_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sys_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transaction-level model: pending slots, one active transaction with timestamps
  bit          m_pend [2];
  bit          m_rw   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  bit          m_active;
  int          m_owner;
  int          m_iss;
  int          m_done;
  bit          m_last;
  bit          e_mrw;
  logic [31:0] e_maddr;
  logic [31:0] e_mwd;
  logic [31:0] e_rdata [2];
  logic [31:0] cur_rd;
  int          cyc;
  int          model_dones;
  int          dut_dones;
  bit          obs_i_done;
  bit          obs_d_done;
  int          last_i_done_cyc;
  int          last_d_done_cyc;
  int          d_done_cnt;
  int          addr80_issues;
  logic [31:0] memv [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (memv.exists(a)) return memv[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p]  = 1'b0;
      e_rdata[p] = '0;
    end
    m_active = 1'b0;
    m_last   = 1'b0;
    e_mrw    = 1'b0;
    e_maddr  = '0;
    e_mwd    = '0;
  endtask

  task automatic run_cycle(input bit si, input bit irw, input logic [31:0] ia, input logic [31:0] iw,
                           input bit sd, input bit drw, input logic [31:0] da, input logic [31:0] dw);
    bit x_idone, x_ddone, x_busy, x_mstb, x_grant, x_mrw;
    logic [31:0] x_maddr, x_mwd, rd_drive;
    int w;
    @(posedge clock);
    #1;
    cyc++;
    x_idone  = 1'b0;
    x_ddone  = 1'b0;
    x_busy   = 1'b0;
    x_mstb   = 1'b0;
    rd_drive = $urandom;
    if (m_active && cyc >= m_iss) begin
      x_busy = 1'b1;
      if (cyc == m_iss) x_mstb = 1'b1;
      if (cyc == m_done - 1) begin
        rd_drive = mem_read(m_addr[m_owner]);
        cur_rd   = rd_drive;
      end
      if (cyc == m_done) begin
        if (m_owner == 1) x_ddone = 1'b1;
        else              x_idone = 1'b1;
        if (!m_rw[m_owner]) e_rdata[m_owner] = cur_rd;
      end
    end
    x_grant = m_last;
    x_mrw   = e_mrw;
    x_maddr = e_maddr;
    x_mwd   = e_mwd;

    bus.i_strobe  = si;  bus.i_rw = irw; bus.i_addr = ia; bus.i_wdata = iw;
    bus.d_strobe  = sd;  bus.d_rw = drw; bus.d_addr = da; bus.d_wdata = dw;
    bus.mem_rdata = rd_drive;

    if (m_active && cyc == m_done) begin
      m_active = 1'b0;
      if (m_rw[m_owner]) memv[m_addr[m_owner]] = m_wd[m_owner];
      m_pend[m_owner] = 1'b0;
      model_dones++;
    end else if (!m_active && (m_pend[0] || m_pend[1])) begin
      w        = (m_pend[1] && (!m_pend[0] || !m_last)) ? 1 : 0;
      m_owner  = w;
      m_last   = (w == 1);
      m_active = 1'b1;
      m_iss    = cyc + 1;
      m_done   = cyc + 2 + W;
      e_mrw    = m_rw[w];
      e_maddr  = m_addr[w];
      e_mwd    = m_wd[w];
    end
    if (si && !m_pend[0]) begin
      m_pend[0] = 1'b1; m_rw[0] = irw; m_addr[0] = ia; m_wd[0] = iw;
    end
    if (sd && !m_pend[1]) begin
      m_pend[1] = 1'b1; m_rw[1] = drw; m_addr[1] = da; m_wd[1] = dw;
    end

    @(negedge clock);
    check_eq("i_done",     64'(bus.i_done),     64'(x_idone));
    check_eq("d_done",     64'(bus.d_done),     64'(x_ddone));
    check_eq("busy",       64'(bus.busy),       64'(x_busy));
    check_eq("mem_strobe", 64'(bus.mem_strobe), 64'(x_mstb));
    check_eq("grant_d",    64'(bus.grant_d),    64'(x_grant));
    check_eq("mem_rw",     64'(bus.mem_rw),     64'(x_mrw));
    check_eq("mem_addr",   64'(bus.mem_addr),   64'(x_maddr));
    check_eq("mem_wdata",  64'(bus.mem_wdata),  64'(x_mwd));
    check_eq("i_rdata",    64'(bus.i_rdata),    64'(e_rdata[0]));
    check_eq("d_rdata",    64'(bus.d_rdata),    64'(e_rdata[1]));
    obs_i_done = bus.i_done;
    obs_d_done = bus.d_done;
    if (bus.i_done) begin dut_dones++; last_i_done_cyc = cyc; end
    if (bus.d_done) begin dut_dones++; last_d_done_cyc = cyc; d_done_cnt++; end
    if (bus.mem_strobe && bus.mem_addr == 32'h80) addr80_issues++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.i_strobe = 1'b0;
    bus.d_strobe = 1'b0;
    cyc++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc++;
    model_reset();
    obs_i_done = 1'b0;
    obs_d_done = 1'b0;
    @(negedge clock);
    check_eq("rst_i_done",     64'(bus.i_done),     64'd0);
    check_eq("rst_d_done",     64'(bus.d_done),     64'd0);
    check_eq("rst_busy",       64'(bus.busy),       64'd0);
    check_eq("rst_grant_d",    64'(bus.grant_d),    64'd0);
    check_eq("rst_mem_strobe", 64'(bus.mem_strobe), 64'd0);
    check_eq("rst_mem_rw",     64'(bus.mem_rw),     64'd0);
    check_eq("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
    check_eq("rst_mem_wdata",  64'(bus.mem_wdata),  64'd0);
    check_eq("rst_i_rdata",    64'(bus.i_rdata),    64'd0);
    check_eq("rst_d_rdata",    64'(bus.d_rdata),    64'd0);
  endtask

  initial begin
    int t;
    int k;
    int n;
    bit si, sd;
    cyc = 0; model_dones = 0; dut_dones = 0;
    last_i_done_cyc = -1; last_d_done_cyc = -1;
    d_done_cnt = 0; addr80_issues = 0;
    bus.i_strobe = 0; bus.i_rw = 0; bus.i_addr = 0; bus.i_wdata = 0;
    bus.d_strobe = 0; bus.d_rw = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.mem_rdata = 0;
    model_reset();
    memv[32'h100] = 32'hDEAD_BEEF;
    memv[32'h500] = 32'hA5A5_A5A5;

    // uncontended I read
    do_reset();
    run_cycle(1, 0, 32'h100, 32'h0, 0, 0, 0, 0);
    t = cyc;
    idle(8);
    check_eq("lat_i_read", 64'(last_i_done_cyc), 64'(t + 3 + W));
    check_eq("i_rdata_100", 64'(bus.i_rdata), 64'h0000_0000_DEAD_BEEF);

    // simultaneous strobes right after reset: D first, then I
    do_reset();
    run_cycle(1, 0, 32'h300, 32'h0, 1, 0, 32'h200, 32'h0);
    t = cyc;
    idle(14);
    check_eq("lat_tie_d", 64'(last_d_done_cyc), 64'(t + 3 + W));
    check_eq("lat_tie_i", 64'(last_i_done_cyc), 64'(t + 8 + W));

    // D read of A5A5A5A5, then a D write that must not disturb d_rdata
    run_cycle(0, 0, 0, 0, 1, 0, 32'h500, 32'h0);
    idle(7);
    run_cycle(0, 0, 0, 0, 1, 1, 32'h40, 32'h1234_5678);
    idle(7);
    check_eq("d_rdata_after_wr", 64'(bus.d_rdata), 64'h0000_0000_A5A5_A5A5);

    // second D strobe while the first is still pending is dropped
    d_done_cnt = 0; addr80_issues = 0;
    run_cycle(0, 0, 0, 0, 1, 1, 32'h40, 32'h1111_2222);
    run_cycle(0, 0, 0, 0, 1, 0, 32'h80, 32'h0);
    idle(10);
    check_eq("d_ignored_done_cnt", 64'(d_done_cnt), 64'd1);
    check_eq("d_ignored_addr80",   64'(addr80_issues), 64'd0);

    // reset in the first WAIT cycle of an I read, then a clean request
    do_reset();
    last_i_done_cyc = -1;
    run_cycle(1, 0, 32'h700, 32'h0, 0, 0, 0, 0);
    idle(2);
    do_reset();
    idle(6);
    check_eq("rst_abandon_no_done", 64'(last_i_done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    run_cycle(1, 0, 32'h100, 32'h0, 0, 0, 0, 0);
    t = cyc;
    idle(8);
    check_eq("rst_then_lat", 64'(last_i_done_cyc), 64'(t + 3 + W));
    check_eq("rst_then_rdata", 64'(bus.i_rdata), 64'h0000_0000_DEAD_BEEF);

    // back-to-back alternation: each port re-strobes the cycle after its own done
    do_reset();
    k = 0;
    run_cycle(1, 0, 32'h1000, 32'h0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 1, 0, 32'h2000, 32'h0);
    n = 0;
    while (k < 20 && n < 600) begin
      si = obs_i_done;
      sd = obs_d_done;
      run_cycle(si, 1'($urandom), $urandom_range(255, 0) << 2, $urandom,
                sd, 1'($urandom), $urandom_range(255, 0) << 2, $urandom);
      if (obs_i_done || obs_d_done) begin
        check_eq("alternate", 64'(obs_d_done), 64'(k % 2));
        k++;
      end
      n++;
    end
    check_eq("alt_count", 64'(k), 64'd20);
    idle(15);

    // randomized traffic
    for (int r = 0; r < 1500; r++) begin
      run_cycle(($urandom_range(2, 0) == 0), 1'($urandom), $urandom_range(63, 0) << 2, $urandom,
                ($urandom_range(2, 0) == 0), 1'($urandom), $urandom_range(63, 0) << 2, $urandom);
      if ($urandom_range(299, 0) == 0) do_reset();
    end
    idle(15);
    check_eq("done_total", 64'(dut_dones), 64'(model_dones));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end
endmodule
